// File: rtl/debug_dump_streamer_if.sv
// Probe and byte-stream signals between the debug dump streamer, the core/memory
// probe ports and the downstream byte sink (UART TX or host bridge).
interface debug_dump_streamer_if #(
    parameter int N = 64
);
    logic [4:0]   checkra;
    logic [N-1:0] checkr;
    logic [7:0]   checkma;
    logic [31:0]  checkm;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output checkra,
        output checkma,
        output tx_data,
        output tx_valid,
        input  checkr,
        input  checkm,
        input  tx_ready
    );

    modport slave (
        input  checkra,
        input  checkma,
        input  tx_data,
        input  tx_valid,
        output checkr,
        output checkm,
        output tx_ready
    );
endinterface

// File: rtl/debug_dump_streamer.sv
// Walks the core register file and low data memory through the probe ports and
// streams a SYNC-prefixed, LSB-first byte frame over a valid/ready link.
module debug_dump_streamer #(
    parameter int         N    = 64,
    parameter int         NREG = 32,
    parameter int         NMEM = 16,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    debug_dump_streamer_if.master bus
);

    localparam int NB   = N / 8;
    localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int MW   = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam int CMAX = (NB > 4) ? NB : 4;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [RW-1:0] RLAST  = RW'(NREG - 1);
    localparam logic [MW-1:0] MLAST  = MW'(NMEM - 1);
    localparam logic [CW-1:0] RBYTES = CW'(NB);
    localparam logic [CW-1:0] MBYTES = CW'(4);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RADDR,
        S_RSEND,
        S_MADDR,
        S_MSEND,
        S_FIN
    } state_t;

    state_t        state, state_nx;
    logic [RW-1:0] ra;
    logic [MW-1:0] ma;
    logic [N-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          last_byte;

    assign xfer      = bus.tx_valid & bus.tx_ready;
    assign last_byte = (cnt == ONE);

    // Counters are sized to the dump range; the probe ports are zero-extended.
    assign bus.checkra = 5'(ra);
    assign bus.checkma = 8'(ma);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_HDR;
            end
            S_HDR: begin
                busy         = 1'b1;
                bus.tx_valid = 1'b1;
                bus.tx_data  = SYNC;
                if (xfer) state_nx = S_RADDR;
            end
            S_RADDR: begin
                busy     = 1'b1;
                state_nx = S_RSEND;
            end
            S_RSEND: begin
                busy         = 1'b1;
                bus.tx_valid = 1'b1;
                bus.tx_data  = sh[7:0];
                if (xfer && last_byte) state_nx = (ra == RLAST) ? S_MADDR : S_RADDR;
            end
            S_MADDR: begin
                busy     = 1'b1;
                state_nx = S_MSEND;
            end
            S_MSEND: begin
                busy         = 1'b1;
                bus.tx_valid = 1'b1;
                bus.tx_data  = sh[7:0];
                if (xfer && last_byte) state_nx = (ma == MLAST) ? S_FIN : S_MADDR;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Probe addresses, shift register and byte counter. The shift register only
    // moves on a transfer, which keeps tx_data stable while the sink stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            ra  <= '0;
            ma  <= '0;
            // NOTE: the shift register is reset too; it is a handful of flops,
            // not a memory array, and a known value keeps tx_data clean.
            sh  <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                S_HDR: begin
                    if (xfer) ra <= '0;
                end
                S_RADDR: begin
                    sh  <= bus.checkr;
                    cnt <= RBYTES;
                end
                S_RSEND: begin
                    if (xfer) begin
                        sh  <= sh >> 8;
                        cnt <= cnt - ONE;
                        if (last_byte) begin
                            if (ra == RLAST) ma <= '0;
                            else             ra <= ra + RW'(1);
                        end
                    end
                end
                S_MADDR: begin
                    sh  <= N'(bus.checkm);
                    cnt <= MBYTES;
                end
                S_MSEND: begin
                    if (xfer) begin
                        sh  <= sh >> 8;
                        cnt <= cnt - ONE;
                        if (last_byte && (ma != MLAST)) ma <= ma + MW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        (bus.tx_valid && !bus.tx_ready) |=> (bus.tx_valid && $stable(bus.tx_data)));

    a_reg_range: assert property (@(posedge clk) disable iff (reset)
        32'(bus.checkra) < NREG);

    a_mem_range: assert property (@(posedge clk) disable iff (reset)
        32'(bus.checkma) < NMEM);

endmodule

// File: tb/tb_debug_dump_streamer.sv
// Scoreboard bench for debug_dump_streamer: expected frames are queued at start
// and compared byte by byte as the stream is accepted.
module tb_debug_dump_streamer;

    localparam int N            = 64;
    localparam int NREG         = 32;
    localparam int NMEM         = 16;
    localparam int FRAME_BYTES  = 1 + NREG * N / 8 + NMEM * 4;
    localparam int FRAME_CYCLES = 1 + NREG * (1 + N / 8) + NMEM * 5;
    localparam int WAIT_BOUND   = 5000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    debug_dump_streamer_if #(.N(N)) bus ();

    debug_dump_streamer #(
        .N   (N),
        .NREG(NREG),
        .NMEM(NMEM),
        .SYNC(8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Core and memory models: combinational lookups on the probe addresses.
    logic [63:0] regs [NREG];
    logic [31:0] mem  [NMEM];

    assign bus.checkr = regs[bus.checkra];
    assign bus.checkm = (bus.checkma < 8'(NMEM)) ? mem[bus.checkma[3:0]] : 32'hBAD0_BAD0;

    int         checks      = 0;
    int         failures    = 0;
    logic [7:0] sb [$];
    int         cyc         = 0;
    int         bytes_total = 0;
    int         done_total  = 0;
    int         last_xfer_cyc = 0;
    int         frame_base  = 0;
    bit         mon_en      = 1'b0;
    int         rdy_mode    = 0;
    logic [7:0] cap [FRAME_BYTES];
    bit         stalled_prev = 1'b0;
    logic [7:0] prev_data    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Sink ready: held high in mode 0, roughly 30% duty in mode 1.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    // Output monitor: sampled mid-cycle, so values seen here are the ones the
    // next rising edge acts on.
    always @(negedge clk) begin
        int idx;
        if (mon_en) begin
            if (busy) check("checkma_max", 64'(bus.checkma <= 8'(NMEM - 1)), 64'd1);
            if (stalled_prev) begin
                check("stall_valid", 64'(bus.tx_valid), 64'd1);
                check("stall_data", 64'(bus.tx_data), 64'(prev_data));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (sb.size() == 0) begin
                    check("extra_byte", 64'(bus.tx_data), 64'hFFFF);
                end else begin
                    check("byte", 64'(bus.tx_data), 64'(sb.pop_front()));
                end
                idx = bytes_total - frame_base;
                if (idx >= 0 && idx < FRAME_BYTES) cap[idx] = bus.tx_data;
                bytes_total++;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_total++;
                check("done_latency", 64'(cyc), 64'(last_xfer_cyc + 1));
            end
            stalled_prev = bus.tx_valid && !bus.tx_ready;
            prev_data    = bus.tx_data;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic push_expected();
        sb.push_back(8'hA5);
        for (int r = 0; r < NREG; r++)
            for (int b = 0; b < N / 8; b++) sb.push_back(regs[r][8*b +: 8]);
        for (int m = 0; m < NMEM; m++)
            for (int b = 0; b < 4; b++) sb.push_back(mem[m][8*b +: 8]);
    endtask

    // Entered and left just after a rising edge.
    task automatic launch_frame(input int mode, output int c0);
        rdy_mode   = mode;
        frame_base = bytes_total;
        push_expected();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        c0 = cyc;
        check("first_valid", 64'(bus.tx_valid), 64'd1);
        check("first_busy", 64'(busy), 64'd1);
        check("first_sync", 64'(bus.tx_data), 64'hA5);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < WAIT_BOUND; i++) begin
            if (bytes_total - frame_base >= n) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!reached) check("wait_bytes_timeout", 64'(bytes_total - frame_base), 64'(n));
    endtask

    task automatic run_frame(input int mode, input int restart_at);
        int  c0;
        int  done_base;
        bit  seen;
        logic [7:0] r5b [8];
        logic [7:0] m3b [4];
        r5b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        m3b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        done_base = done_total;
        launch_frame(mode, c0);
        if (restart_at > 0) begin
            wait_bytes(restart_at);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < WAIT_BOUND; i++) begin
            @(negedge clk);
            if (done_total > done_base) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        repeat (4) @(negedge clk);
        check("frame_bytes", 64'(bytes_total - frame_base), 64'(FRAME_BYTES));
        check("done_count", 64'(done_total - done_base), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("checkma_final", 64'(bus.checkma), 64'(NMEM - 1));
        if (mode == 0) check("frame_cycles", 64'(last_xfer_cyc - c0 + 1), 64'(FRAME_CYCLES));
        check("byte0", 64'(cap[0]), 64'hA5);
        for (int i = 0; i < 8; i++) check("r5_byte", 64'(cap[41 + i]), 64'(r5b[i]));
        for (int i = 0; i < 4; i++) check("mem3_byte", 64'(cap[1 + 256 + 12 + i]), 64'(m3b[i]));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_frame();
        int c0;
        launch_frame(0, c0);
        wait_bytes(50);
        mon_en = 1'b0;
        reset  = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_checkra", 64'(bus.checkra), 64'd0);
        check("rst_data", 64'(bus.tx_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_valid", 64'(bus.tx_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 mon_en = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) regs[r] = {$urandom(), $urandom()};
        for (int m = 0; m < NMEM; m++) mem[m] = $urandom();
        regs[5] = 64'h0123_4567_89AB_CDEF;
        mem[3]  = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_valid", 64'(bus.tx_valid), 64'd0);
            check("idle_checkra", 64'(bus.checkra), 64'd0);
            check("idle_checkma", 64'(bus.checkma), 64'd0);
        end
        check("idle_no_done", 64'(done_total), 64'd0);
        @(posedge clk);
        #1;

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(0, 100);
        reset_mid_frame();
        run_frame(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got %0d bytes expected run to finish", bytes_total);
        $fatal(1, "simulation time limit reached");
    end

endmodule
